// File: rtl/run_length_detector.sv
// Serial run detector: flags RUN_LEN consecutive matching samples, with selectable
// polarity, level/pulse output, saturating live run length and a wrapping event count.
module run_length_detector #(
   parameter int RUN_LEN = 3,
   parameter int CNT_W   = 8,
   parameter int DET_W   = 16
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             en,
   input  logic             stream,
   input  logic             polarity,
   input  logic             pulse_mode,
   input  logic             clear,
   output logic             bingo,
   output logic [CNT_W-1:0] run_len,
   output logic [DET_W-1:0] det_count
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_HIT} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] RUN_M1  = CNT_W'(RUN_LEN - 1);
   localparam logic [CNT_W-1:0] RUN_TGT = CNT_W'(RUN_LEN);
   localparam logic [DET_W-1:0] DET_ONE = DET_W'(1);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_ONE;
   endfunction

   function automatic state_t state_of(input logic [CNT_W-1:0] c);
      if (c == '0)
         return S_IDLE;
      else if (c < RUN_TGT)
         return S_RUN;
      else
         return S_HIT;
   endfunction

   logic             match;
   logic             hit_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             hit;
   state_t           state;

   assign match   = en & (stream ^ polarity);
   assign cnt_nxt = match ? sat_inc(cnt) : '0;
   // Saturation keeps cnt from revisiting RUN_LEN-1 inside one run, so a run hits once.
   assign hit_nxt = match & (cnt == RUN_M1);

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         cnt       <= '0;
         hit       <= 1'b0;
         det_count <= '0;
         state     <= S_IDLE;
      end else if (clear) begin
         cnt       <= '0;
         hit       <= 1'b0;
         det_count <= '0;
         state     <= S_IDLE;
      end else if (en) begin
         cnt   <= cnt_nxt;
         hit   <= hit_nxt;
         state <= state_of(cnt_nxt);
         if (hit_nxt)
            det_count <= det_count + DET_ONE;
      end else begin
         hit <= 1'b0;
      end
   end

   assign run_len = cnt;
   assign bingo   = pulse_mode ? hit : (state == S_HIT);

endmodule
